// File: rtl/vec_alu_seq_if.sv
// rtl/vec_alu_seq_if.sv - command, lane broadcast/collect and writeback bundle for vec_alu_seq
//
// Purpose: groups every non-clock/reset signal of vec_alu_seq.
//   slave  modport : the sequencer (receives commands, drives lanes, offers writeback)
//   master modport : the environment (issues commands, models lanes, sinks writeback)
// Signals:
//   cmd_valid/cmd_ready, cmd_opcode[5:0], cmd_vsew[2:0], cmd_op_type[2:0], cmd_vd[4:0]
//   lane_run, lane_opcode[5:0], lane_vsew[2:0], lane_op_type[2:0], lane_nb_lanes[1:0]
//   lane_done[NL-1:0], lane_vd[NL*64-1:0], lane_reg_index[NL*10-1:0]
//   wb_valid/wb_ready, wb_data[VLEN-1:0], wb_vd[4:0], busy, err
interface vec_alu_seq_if #(
  parameter int VLEN        = 128,
  parameter int NLANES_LOG2 = 2
);
  localparam int NL = 1 << NLANES_LOG2;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [5:0]       cmd_opcode;
  logic [2:0]       cmd_vsew;
  logic [2:0]       cmd_op_type;
  logic [4:0]       cmd_vd;

  logic             lane_run;
  logic [5:0]       lane_opcode;
  logic [2:0]       lane_vsew;
  logic [2:0]       lane_op_type;
  logic [1:0]       lane_nb_lanes;
  logic [NL-1:0]    lane_done;
  logic [NL*64-1:0] lane_vd;
  logic [NL*10-1:0] lane_reg_index;

  logic             wb_valid;
  logic             wb_ready;
  logic [VLEN-1:0]  wb_data;
  logic [4:0]       wb_vd;

  logic             busy;
  logic             err;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_vsew, cmd_op_type, cmd_vd,
    output cmd_ready,
    output lane_run, lane_opcode, lane_vsew, lane_op_type, lane_nb_lanes,
    input  lane_done, lane_vd, lane_reg_index,
    output wb_valid, wb_data, wb_vd,
    input  wb_ready,
    output busy, err
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_vsew, cmd_op_type, cmd_vd,
    input  cmd_ready,
    input  lane_run, lane_opcode, lane_vsew, lane_op_type, lane_nb_lanes,
    output lane_done, lane_vd, lane_reg_index,
    input  wb_valid, wb_data, wb_vd,
    output wb_ready,
    input  busy, err
  );
endinterface

// File: rtl/vec_alu_seq.sv
// rtl/vec_alu_seq.sv - vector ALU sequencer: command accept, lane run/collect, writeback
//
// Purpose: accepts one vector command at a time, broadcasts it to NL external lane
// ALUs, assembles their result slices into a VLEN-bit buffer, then offers the buffer
// for writeback. Optional RUN watchdog enabled by defining VEC_ALU_SEQ_TIMEOUT_EN.
// Ports:
//   clk    : rising-edge clock
//   resetn : synchronous active-low reset
//   bus    : vec_alu_seq_if.slave (command, lane, writeback, busy/err signals)
module vec_alu_seq #(
  parameter int VLEN        = 128,
  parameter int LANE_WIDTH  = 3,
  parameter int NLANES_LOG2 = 2
) (
  input  logic           clk,
  input  logic           resetn,
  vec_alu_seq_if.slave   bus
);
  localparam int NL = 1 << NLANES_LOG2;
  localparam int LW = 1 << LANE_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

  state_t          state_q, state_d;
  logic [5:0]      opcode_q, opcode_d;
  logic [2:0]      vsew_q, vsew_d;
  logic [2:0]      op_type_q, op_type_d;
  logic [4:0]      vd_q, vd_d;
  logic [VLEN-1:0] buf_q, buf_d;
  logic [NL-1:0]   mask_q, mask_d;
  logic            err_q, err_d;

  logic            cmd_legal;
  logic [NL-1:0]   preset;
  logic [VLEN-1:0] wmask, wdata;
  logic            unused_lane_bits;

`ifdef VEC_ALU_SEQ_TIMEOUT_EN
  localparam int TMO = 4 * VLEN;
  localparam int CW  = $clog2(TMO + 1);
  logic [CW-1:0]   tmo_cnt_q, tmo_cnt_d;
`endif

  // Only the low LW bits of each 64-bit lane result are consumed.
  assign unused_lane_bits = ^bus.lane_vd;

  always_comb begin
    cmd_legal = (bus.cmd_opcode inside {6'b000000, 6'b001001, 6'b001010, 6'b001011})
             && (bus.cmd_op_type inside {3'b001, 3'b010, 3'b100})
             && !bus.cmd_vsew[2]
             && ((8 << bus.cmd_vsew[1:0]) <= VLEN);
    // Lanes beyond the element count never report done, so mark them finished up front.
    preset = '0;
    for (int i = 0; i < NL; i++) begin
      if (i >= (VLEN >> (int'(bus.cmd_vsew[1:0]) + 3))) preset[i] = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    vsew_d    = vsew_q;
    op_type_d = op_type_q;
    vd_d      = vd_q;
    buf_d     = buf_q;
    mask_d    = mask_q;
    err_d     = 1'b0;
    wmask     = '0;
    wdata     = '0;
`ifdef VEC_ALU_SEQ_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (cmd_legal) begin
            opcode_d  = bus.cmd_opcode;
            vsew_d    = bus.cmd_vsew;
            op_type_d = bus.cmd_op_type;
            vd_d      = bus.cmd_vd;
            buf_d     = '0;
            mask_d    = preset;
            state_d   = RUN;
`ifdef VEC_ALU_SEQ_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        // A slice starting at or past VLEN shifts out entirely; one straddling the
        // top is clipped by the VLEN-wide shift.
        for (int i = 0; i < NL; i++) begin
          wmask = VLEN'({LW{1'b1}}) << bus.lane_reg_index[i*10 +: 10];
          wdata = VLEN'(bus.lane_vd[i*64 +: LW]) << bus.lane_reg_index[i*10 +: 10];
          buf_d = (buf_d & ~wmask) | wdata;
        end
        mask_d = mask_q | bus.lane_done;
        if (&mask_d) begin
          state_d = WB;
        end
`ifdef VEC_ALU_SEQ_TIMEOUT_EN
        else if (tmo_cnt_q == CW'(TMO - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CW'(1);
        end
`endif
      end
      WB: begin
        if (bus.wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      opcode_q  <= '0;
      vsew_q    <= '0;
      op_type_q <= '0;
      vd_q      <= '0;
      buf_q     <= '0;
      mask_q    <= '0;
      err_q     <= 1'b0;
`ifdef VEC_ALU_SEQ_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      vsew_q    <= vsew_d;
      op_type_q <= op_type_d;
      vd_q      <= vd_d;
      buf_q     <= buf_d;
      mask_q    <= mask_d;
      err_q     <= err_d;
`ifdef VEC_ALU_SEQ_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  assign bus.cmd_ready     = (state_q == IDLE);
  assign bus.lane_run      = (state_q == RUN);
  assign bus.lane_opcode   = opcode_q;
  assign bus.lane_vsew     = vsew_q;
  assign bus.lane_op_type  = op_type_q;
  assign bus.lane_nb_lanes = 2'(NLANES_LOG2);
  assign bus.wb_valid      = (state_q == WB);
  assign bus.wb_data       = buf_q;
  assign bus.wb_vd         = vd_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.err           = err_q;
endmodule
